riscv32_lsu: RTL and testbench

Load/store unit in the MEM stage, directly downstream of the RV32I/RV32IM ALU.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs one data-memory transaction over a valid/ready bus.
- Returns sign- or zero-extended load data to writeback.
- Stalls the pipeline while a transaction is outstanding, and reports misalignment and bus timeout.

---
 rtl/riscv32_lsu.sv | 173 +++++++++++++++++
 tb/tb_riscv32_lsu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv32_lsu.sv
// riscv32_lsu: MEM-stage load/store unit. Runs one data-memory transaction
// per instruction over a valid/ready bus. Stores get byte strobes and lanes
// replicated to match; loads get extended to 32 bits. The unit also reports
// misaligned or illegal accesses and bus timeouts.
//
// state | meaning
// IDLE  | waiting for req_valid; fault check and request latch
// BUS   | dmem_valid held, waiting for dmem_ready or timeout
// RESP  | one-cycle resp_valid pulse with data/error flags
module riscv32_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_W          = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_wen,
   input  logic [2:0]  req_fun,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        dmem_valid,
   input  logic        dmem_ready,
   output logic [31:0] dmem_addr,
   output logic        dmem_wen,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        lsu_stall,
   output logic        err_misalign,
   output logic        err_bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // A zero timeout disables the bus watchdog entirely.
   localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       fun_q;
   logic [1:0]       lo_q;

   logic             fault;
   logic [3:0]       strb_n;
   logic [31:0]      wdata_n;
   logic [31:0]      byte_sh;
   logic [31:0]      half_sh;
   logic [31:0]      load_ext;

   // A request is faulted when its alignment or its funct3 is illegal.
   // BU/HU are load-only encodings, so a store using them is a fault too.
   always_comb begin
      fault = 1'b0;
      case (req_fun)
         3'b000:  fault = 1'b0;
         3'b001:  fault = req_addr[0];
         3'b010:  fault = |req_addr[1:0];
         3'b100:  fault = req_wen;
         3'b101:  fault = req_wen | req_addr[0];
         default: fault = 1'b1;
      endcase
   end

   // Byte strobes and lane-replicated store data for the next bus request.
   always_comb begin
      strb_n  = 4'hf;
      wdata_n = req_wdata;
      if (req_wen) begin
         case (req_fun[1:0])
            2'b00:   strb_n = 4'b0001 << req_addr[1:0];
            2'b01:   strb_n = 4'b0011 << req_addr[1:0];
            default: strb_n = 4'hf;
         endcase
      end
      case (req_fun[1:0])
         2'b00:   wdata_n = {4{req_wdata[7:0]}};
         2'b01:   wdata_n = {2{req_wdata[15:0]}};
         default: wdata_n = req_wdata;
      endcase
   end

   // Extract the addressed byte/halfword from the read word and extend it.
   always_comb begin
      byte_sh  = dmem_rdata >> {lo_q, 3'b000};
      half_sh  = dmem_rdata >> {lo_q[1], 4'b0000};
      load_ext = '0;
      case (fun_q)
         3'b000:  load_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
         3'b001:  load_ext = {{16{half_sh[15]}}, half_sh[15:0]};
         3'b010:  load_ext = dmem_rdata;
         3'b100:  load_ext = {24'h0, byte_sh[7:0]};
         3'b101:  load_ext = {16'h0, half_sh[15:0]};
         default: load_ext = '0;
      endcase
   end

   // The pipeline holds the instruction until its completion pulse.
   assign lsu_stall = req_valid & ~resp_valid;

   // Main sequencer with registered bus and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         fun_q        <= '0;
         lo_q         <= '0;
         dmem_valid   <= 1'b0;
         dmem_addr    <= '0;
         dmem_wen     <= 1'b0;
         dmem_wstrb   <= '0;
         dmem_wdata   <= '0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         err_misalign <= 1'b0;
         err_bus      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  if (fault) begin
                     state        <= ST_RESP;
                     resp_valid   <= 1'b1;
                     err_misalign <= 1'b1;
                     resp_rdata   <= '0;
                  end else begin
                     state      <= ST_BUS;
                     cnt        <= '0;
                     fun_q      <= req_fun;
                     lo_q       <= req_addr[1:0];
                     dmem_valid <= 1'b1;
                     dmem_addr  <= {req_addr[31:2], 2'b00};
                     dmem_wen   <= req_wen;
                     dmem_wstrb <= strb_n;
                     dmem_wdata <= wdata_n;
                  end
               end
            end
            ST_BUS: begin
               cnt <= cnt + CNT_W'(1);
               // Ready takes priority over a timeout landing on the same cycle.
               if (dmem_ready) begin
                  state      <= ST_RESP;
                  dmem_valid <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_rdata <= dmem_wen ? 32'h0 : load_ext;
               end else if (TO_EN && (cnt == TO_LAST)) begin
                  state      <= ST_RESP;
                  dmem_valid <= 1'b0;
                  resp_valid <= 1'b1;
                  err_bus    <= 1'b1;
                  resp_rdata <= '0;
               end
            end
            ST_RESP: begin
               state        <= ST_IDLE;
               resp_valid   <= 1'b0;
               resp_rdata   <= '0;
               err_misalign <= 1'b0;
               err_bus      <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv32_lsu.sv
// tb_riscv32_lsu: directed and random load/store transactions against a
// behavioural model of the LSU's access rules. The bench acts as the bus.
module tb_riscv32_lsu;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_wen = 1'b0;
   logic [2:0]  req_fun = 3'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        dmem_valid;
   logic        dmem_ready = 1'b0;
   logic [31:0] dmem_addr;
   logic        dmem_wen;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        lsu_stall;
   logic        err_misalign;
   logic        err_bus;

   int total = 0;
   int bad   = 0;

   riscv32_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_wen(req_wen), .req_fun(req_fun),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
      .dmem_wen(dmem_wen), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .lsu_stall(lsu_stall),
      .err_misalign(err_misalign), .err_bus(err_bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---- reference model: access rules in plain arithmetic ----
   function automatic bit m_fault(input bit wen, input int fun, input int unsigned addr);
      case (fun)
         0:       return 0;
         1:       return (addr % 2) != 0;
         2:       return (addr % 4) != 0;
         4:       return wen;
         5:       return wen || ((addr % 2) != 0);
         default: return 1;
      endcase
   endfunction

   function automatic int unsigned m_strb(input bit wen, input int fun, input int unsigned addr);
      int unsigned n;
      if (!wen) return 15;
      n = 1 << fun;
      return ((1 << n) - 1) << (addr % 4);
   endfunction

   function automatic int unsigned m_wdata(input int fun, input int unsigned wd);
      if (fun == 0) return (wd & 32'hff) * 32'h01010101;
      if (fun == 1) return (wd & 32'hffff) * 32'h00010001;
      return wd;
   endfunction

   function automatic int unsigned m_load(input int fun, input int unsigned addr, input int unsigned rd);
      int unsigned b, h;
      b = (rd >> (8 * (addr % 4))) & 32'hff;
      h = (rd >> (16 * ((addr / 2) % 2))) & 32'hffff;
      case (fun)
         0:       return (b >= 128) ? b + 32'hffffff00 : b;
         1:       return (h >= 32768) ? h + 32'hffff0000 : h;
         2:       return rd;
         4:       return b;
         5:       return h;
         default: return 0;
      endcase
   endfunction

   // One full transaction. Entered just after a rising edge with the DUT idle.
   // waits = ready-low BUS cycles before ready; waits >= TO means never ready.
   task automatic txn(input bit wen, input int fun, input int unsigned addr,
                      input int unsigned wd, input int unsigned rd, input int waits);
      bit flt, tmo, got;
      int cyc, vc, stall, lat;
      flt = m_fault(wen, fun, addr);
      tmo = !flt && (waits >= TO);
      lat = flt ? 1 : (tmo ? 1 + TO : 2 + waits);
      req_valid = 1'b1; req_wen = wen; req_fun = 3'(fun);
      req_addr = addr; req_wdata = wd; dmem_ready = 1'b0;
      got = 0; cyc = 0; vc = 0; stall = 0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (lsu_stall) stall++;
         if (dmem_valid) begin
            vc++;
            chk("dmem_addr", dmem_addr, addr & 32'hfffffffc);
            chk("dmem_wen", 32'(dmem_wen), 32'(wen));
            chk("dmem_wstrb", 32'(dmem_wstrb), m_strb(wen, fun, addr));
            if (wen) chk("dmem_wdata", dmem_wdata, m_wdata(fun, wd));
         end
         if (resp_valid) begin
            got = 1;
            dmem_ready = 1'b0;
            chk("latency", 32'(cyc - 1), 32'(lat));
            chk("stall_cycles", 32'(stall), 32'(lat));
            chk("stall_at_resp", 32'(lsu_stall), 32'h0);
            chk("valid_cycles", 32'(vc), flt ? 32'h0 : (tmo ? 32'(TO) : 32'(waits + 1)));
            chk("err_misalign", 32'(err_misalign), 32'(flt));
            chk("err_bus", 32'(err_bus), 32'(tmo));
            chk("resp_rdata", resp_rdata, (flt || tmo || wen) ? 32'h0 : m_load(fun, addr, rd));
         end else if (dmem_valid && !tmo && (vc - 1 == waits)) begin
            dmem_ready = 1'b1; dmem_rdata = rd;
         end else begin
            dmem_ready = 1'b0; dmem_rdata = $urandom;
         end
      end
      if (!got) chk("resp_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("resp_one_cycle", 32'(resp_valid), 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      int fun, w;
      // reset values
      #12;
      chk("rst_dmem_valid", 32'(dmem_valid), 32'h0);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_errs", {30'h0, err_misalign, err_bus}, 32'h0);
      chk("rst_wstrb", 32'(dmem_wstrb), 32'h0);
      chk("rst_addr", dmem_addr, 32'h0);
      chk("rst_wdata", dmem_wdata, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_stall", 32'(lsu_stall), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // LW minimum latency
      txn(0, 2, 32'h100, 0, 32'hdeadbeef, 0);
      // LB / LBU with three wait cycles
      txn(0, 0, 32'h103, 0, 32'h80112233, 3);
      txn(0, 4, 32'h103, 0, 32'h80112233, 3);
      // SB / SH
      txn(1, 0, 32'h202, 32'h000000a5, 0, 0);
      txn(1, 1, 32'h202, 32'h00001234, 0, 1);
      // faults
      txn(0, 2, 32'h102, 0, 0, 0);
      txn(1, 1, 32'h001, 0, 0, 0);
      txn(1, 4, 32'h100, 0, 0, 0);
      txn(0, 3, 32'h100, 0, 0, 0);
      // timeout, then ready on the timeout cycle
      txn(0, 2, 32'h300, 0, 32'h12345678, TO);
      txn(0, 2, 32'h300, 0, 32'h12345678, TO - 1);
      // halfword loads
      txn(0, 1, 32'h402, 0, 32'h8001ffff, 0);
      txn(0, 5, 32'h402, 0, 32'h8001ffff, 2);

      // reset during the second BUS cycle
      req_valid = 1'b1; req_wen = 1'b0; req_fun = 3'b010; req_addr = 32'h40;
      dmem_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_valid", 32'(dmem_valid), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(dmem_valid), 32'h0);
      req_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_resp", 32'(resp_valid), 32'h0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      txn(0, 2, 32'h40, 0, 32'hcafef00d, 0);

      // random traffic
      for (int i = 0; i < 60; i++) begin
         fun = (($urandom % 8) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2)) + ((($urandom % 2) == 0) ? 0 : 4);
         if (fun == 6) fun = 2;
         w = (($urandom % 6) == 0) ? TO : int'($urandom_range(0, 3));
         txn(1'($urandom), fun, $urandom, $urandom, $urandom, w);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
